// File: rtl/apb_router_pkg.sv
// Shared types and constants for the APB peripheral router.
// Imported by the interface, the decoder and the top (apb_periph_router).
package apb_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    localparam int TIMEOUT_CYCLES_DEFAULT = 256;

    // Read data returned on decode misses, timeouts and write transfers
    localparam int unsigned ERR_RDATA = 0;

    // Slave-index width that remains legal when there is only one slave
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_periph_router_if.sv
// Bundle of the upstream APB request/response and the downstream shared/per-slave signals.
// The router uses modport 'slave'; the upstream master and downstream slaves use 'master'.
interface apb_periph_router_if #(
    parameter int NB_SLAVE       = 12,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0]                     s_paddr_i;
    logic [APB_DATA_WIDTH-1:0]                     s_pwdata_i;
    logic                                          s_pwrite_i;
    logic                                          s_psel_i;
    logic                                          s_penable_i;
    logic [APB_DATA_WIDTH-1:0]                     s_prdata_o;
    logic                                          s_pready_o;
    logic                                          s_pslverr_o;

    logic [APB_ADDR_WIDTH-1:0]                     m_paddr_o;
    logic [APB_DATA_WIDTH-1:0]                     m_pwdata_o;
    logic                                          m_pwrite_o;
    logic                                          m_penable_o;
    logic [NB_SLAVE-1:0]                           m_psel_o;
    logic [NB_SLAVE-1:0][APB_DATA_WIDTH-1:0]       m_prdata_i;
    logic [NB_SLAVE-1:0]                           m_pready_i;
    logic [NB_SLAVE-1:0]                           m_pslverr_i;

    modport slave (
        input  s_paddr_i, s_pwdata_i, s_pwrite_i, s_psel_i, s_penable_i,
        output s_prdata_o, s_pready_o, s_pslverr_o,
        output m_paddr_o, m_pwdata_o, m_pwrite_o, m_penable_o, m_psel_o,
        input  m_prdata_i, m_pready_i, m_pslverr_i
    );

    modport master (
        output s_paddr_i, s_pwdata_i, s_pwrite_i, s_psel_i, s_penable_i,
        input  s_prdata_o, s_pready_o, s_pslverr_o,
        input  m_paddr_o, m_pwdata_o, m_pwrite_o, m_penable_o, m_psel_o,
        output m_prdata_i, m_pready_i, m_pslverr_i
    );

endinterface

// File: rtl/apb_router_decoder.sv
// Combinational address decoder: finds the slave whose inclusive window holds addr.
// When windows overlap, the lowest slave index wins.
module apb_router_decoder
    import apb_router_pkg::*;
#(
    parameter int NB_SLAVE       = 12,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int IDX_W          = idx_width(NB_SLAVE)
) (
    input  logic [APB_ADDR_WIDTH-1:0]               addr,
    input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] start_addr,
    input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] end_addr,
    output logic                                    hit,
    output logic [IDX_W-1:0]                        idx
);

    // Scanning downwards lets each lower-index hit override the higher ones
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NB_SLAVE - 1; i >= 0; i--) begin
            if (addr >= start_addr[i] && addr <= end_addr[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_periph_router.sv
// APB 1-to-NB_SLAVE router: decodes, replays the transfer downstream, returns one RESP cycle.
// Optional ACCESS-phase timeout is enabled by defining APB_ROUTER_TIMEOUT_EN.
module apb_periph_router
    import apb_router_pkg::*;
#(
    parameter int NB_SLAVE       = 12,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    apb_periph_router_if.slave                      bus,
    input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVE-1:0][APB_ADDR_WIDTH-1:0] end_addr_i
);

    localparam int IDX_W = idx_width(NB_SLAVE);

    if (NB_SLAVE < 1 || NB_SLAVE > 32) begin : g_bad_nb_slave
        $error("NB_SLAVE must be in 1..32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      write_q;
    logic [IDX_W-1:0]          idx_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;

    logic                      hit;
    logic [IDX_W-1:0]          hit_idx;
    logic                      capture;
    logic                      sel_ready;
    logic                      timeout;

    apb_router_decoder #(
        .NB_SLAVE      (NB_SLAVE),
        .APB_ADDR_WIDTH(APB_ADDR_WIDTH),
        .IDX_W         (IDX_W)
    ) u_decoder (
        .addr      (bus.s_paddr_i),
        .start_addr(start_addr_i),
        .end_addr  (end_addr_i),
        .hit       (hit),
        .idx       (hit_idx)
    );

    assign capture   = bus.s_psel_i && !bus.s_penable_i;
    assign sel_ready = bus.m_pready_i[idx_q];

`ifdef APB_ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Counts unanswered ACCESS cycles; zero whenever a transfer enters ACCESS
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == ST_ACCESS && !sel_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (state_q == ST_ACCESS) && !sel_ready
                     && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (rst_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        addr_q  <= bus.s_paddr_i;
                        wdata_q <= bus.s_pwdata_i;
                        write_q <= bus.s_pwrite_i;
                        idx_q   <= hit_idx;
                        rdata_q <= APB_DATA_WIDTH'(ERR_RDATA);
                        err_q   <= !hit;
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        rdata_q <= write_q ? APB_DATA_WIDTH'(ERR_RDATA) : bus.m_prdata_i[idx_q];
                        err_q   <= bus.m_pslverr_i[idx_q];
                    end else if (timeout) begin
                        rdata_q <= APB_DATA_WIDTH'(ERR_RDATA);
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise latches are inferred.
        state_d         = state_q;
        bus.m_psel_o    = '0;
        bus.m_penable_o = 1'b0;
        bus.s_pready_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (capture) state_d = hit ? ST_SETUP : ST_RESP;
            end
            ST_SETUP: begin
                bus.m_psel_o = NB_SLAVE'(1) << idx_q;
                state_d      = ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.m_psel_o    = NB_SLAVE'(1) << idx_q;
                bus.m_penable_o = 1'b1;
                if (sel_ready || timeout) state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.s_pready_o = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.m_paddr_o   = addr_q;
    assign bus.m_pwdata_o  = wdata_q;
    assign bus.m_pwrite_o  = write_q;
    assign bus.s_prdata_o  = rdata_q;
    assign bus.s_pslverr_o = err_q;

endmodule
